// File: rtl/pipeline_regs_if.sv
// Stage-register bank signal bundle: hazard controls, stage inputs from the core datapath,
// and registered stage outputs consumed by the datapath and the hazard unit.
interface pipeline_regs_if;
    logic        StallF, StallD, FlushD, FlushE;
    logic [31:0] PCNextF, PCF;
    logic [31:0] InstrF, PCPlus4F, InstrD, PCPlus4D;
    logic        RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, SignImmD;
    logic [4:0]  RsD, RtD, RdD;
    logic        RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE;
    logic [4:0]  RsE, RtE, RdE, WriteRegE;
    logic [31:0] ALUOutE, WriteDataE;
    logic        RegWriteM, MemToRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic [4:0]  WriteRegM;
    logic        RegWriteW, MemToRegW, MemWriteW;
    logic [31:0] ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW;
    logic [31:0] StallCount, FlushCount;

    modport master (
        output StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
               RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               RD1D, RD2D, SignImmD, RsD, RtD, RdD, ALUOutE, WriteDataE, ReadDataM,
        input  PCF, InstrD, PCPlus4D,
               RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
               RegWriteM, MemToRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
               RegWriteW, MemToRegW, MemWriteW, ALUOutW, ReadDataW, WriteRegW,
               StallCount, FlushCount
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
               RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
               RD1D, RD2D, SignImmD, RsD, RtD, RdD, ALUOutE, WriteDataE, ReadDataM,
        output PCF, InstrD, PCPlus4D,
               RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, RsE, RtE, RdE, WriteRegE,
               RegWriteM, MemToRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
               RegWriteW, MemToRegW, MemWriteW, ALUOutW, ReadDataW, WriteRegW,
               StallCount, FlushCount
    );
endinterface

// File: rtl/pipeline_regs.sv
// F/D/E/M/W stage registers for the five-stage MIPS core, with stall and flush
// event counters for performance debug.
module pipeline_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           reset,
    pipeline_regs_if.slave bus
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sign_imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic [4:0]  write_reg;
    } mem_reg_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [31:0] alu_out;
        logic [31:0] read_data;
        logic [4:0]  write_reg;
    } wb_reg_t;

    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    ex_reg_t     ex_q, ex_d;
    mem_reg_t    mem_q, mem_d;
    wb_reg_t     wb_q, wb_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic [4:0]  write_reg_e;

    assign write_reg_e = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

    always_comb begin
        pcf_d = bus.StallF ? pcf_q : bus.PCNextF;

        // Flush beats stall so a taken branch still squashes a held instruction.
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        if (bus.FlushD) begin
            instr_d    = '0;
            pc_plus4_d = '0;
        end else if (!bus.StallD) begin
            instr_d    = bus.InstrF;
            pc_plus4_d = bus.PCPlus4F;
        end

        ex_d = '0;
        if (!bus.FlushE) begin
            ex_d.reg_write   = bus.RegWriteD;
            ex_d.mem_to_reg  = bus.MemToRegD;
            ex_d.mem_write   = bus.MemWriteD;
            ex_d.alu_src     = bus.ALUSrcD;
            ex_d.reg_dst     = bus.RegDstD;
            ex_d.alu_control = bus.ALUControlD;
            ex_d.rd1         = bus.RD1D;
            ex_d.rd2         = bus.RD2D;
            ex_d.sign_imm    = bus.SignImmD;
            ex_d.rs          = bus.RsD;
            ex_d.rt          = bus.RtD;
            ex_d.rd          = bus.RdD;
        end

        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.alu_out    = bus.ALUOutE;
        mem_d.write_data = bus.WriteDataE;
        mem_d.write_reg  = write_reg_e;

        wb_d.reg_write   = mem_q.reg_write;
        wb_d.mem_to_reg  = mem_q.mem_to_reg;
        wb_d.mem_write   = mem_q.mem_write;
        wb_d.alu_out     = mem_q.alu_out;
        wb_d.read_data   = bus.ReadDataM;
        wb_d.write_reg   = mem_q.write_reg;

        stall_count_d = stall_count_q + {31'd0, bus.StallD};
        flush_count_d = flush_count_q + {31'd0, bus.FlushD | bus.FlushE};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcf_q         <= RESET_PC;
            instr_q       <= '0;
            pc_plus4_q    <= '0;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            pcf_q         <= pcf_d;
            instr_q       <= instr_d;
            pc_plus4_q    <= pc_plus4_d;
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.PCF         = pcf_q;
    assign bus.InstrD      = instr_q;
    assign bus.PCPlus4D    = pc_plus4_q;
    assign bus.RegWriteE   = ex_q.reg_write;
    assign bus.MemToRegE   = ex_q.mem_to_reg;
    assign bus.MemWriteE   = ex_q.mem_write;
    assign bus.ALUSrcE     = ex_q.alu_src;
    assign bus.RegDstE     = ex_q.reg_dst;
    assign bus.ALUControlE = ex_q.alu_control;
    assign bus.RD1E        = ex_q.rd1;
    assign bus.RD2E        = ex_q.rd2;
    assign bus.SignImmE    = ex_q.sign_imm;
    assign bus.RsE         = ex_q.rs;
    assign bus.RtE         = ex_q.rt;
    assign bus.RdE         = ex_q.rd;
    assign bus.WriteRegE   = write_reg_e;
    assign bus.RegWriteM   = mem_q.reg_write;
    assign bus.MemToRegM   = mem_q.mem_to_reg;
    assign bus.MemWriteM   = mem_q.mem_write;
    assign bus.ALUOutM     = mem_q.alu_out;
    assign bus.WriteDataM  = mem_q.write_data;
    assign bus.WriteRegM   = mem_q.write_reg;
    assign bus.RegWriteW   = wb_q.reg_write;
    assign bus.MemToRegW   = wb_q.mem_to_reg;
    assign bus.MemWriteW   = wb_q.mem_write;
    assign bus.ALUOutW     = wb_q.alu_out;
    assign bus.ReadDataW   = wb_q.read_data;
    assign bus.WriteRegW   = wb_q.write_reg;
    assign bus.StallCount  = stall_count_q;
    assign bus.FlushCount  = flush_count_q;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed bench for pipeline_regs: reset, free-run latency, load-use stall, branch flush,
// stall+flush overlap, counter wrap and asynchronous mid-run reset.
module tb_pipeline_regs;

    localparam logic [31:0] ResetPc = 32'h0040_0000;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    pipeline_regs_if bus ();

    pipeline_regs #(.RESET_PC(ResetPc)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pcf"},      bus.PCF, ResetPc);
        check({tag, "_instrd"},   bus.InstrD, 32'h0);
        check({tag, "_pcplus4d"}, bus.PCPlus4D, 32'h0);
        check({tag, "_regwe"},    {31'd0, bus.RegWriteE}, 32'h0);
        check({tag, "_wrege"},    {27'd0, bus.WriteRegE}, 32'h0);
        check({tag, "_rd1e"},     bus.RD1E, 32'h0);
        check({tag, "_alum"},     bus.ALUOutM, 32'h0);
        check({tag, "_wregw"},    {27'd0, bus.WriteRegW}, 32'h0);
        check({tag, "_regww"},    {31'd0, bus.RegWriteW}, 32'h0);
        check({tag, "_stallc"},   bus.StallCount, 32'h0);
        check({tag, "_flushc"},   bus.FlushCount, 32'h0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.StallF      = 1'b0;
        bus.StallD      = 1'b0;
        bus.FlushD      = 1'b0;
        bus.FlushE      = 1'b0;
        bus.PCNextF     = 32'h0;
        bus.InstrF      = 32'h0;
        bus.PCPlus4F    = 32'h0;
        bus.RegWriteD   = 1'b0;
        bus.MemToRegD   = 1'b0;
        bus.MemWriteD   = 1'b0;
        bus.ALUSrcD     = 1'b0;
        bus.RegDstD     = 1'b0;
        bus.ALUControlD = 3'd0;
        bus.RD1D        = 32'h0;
        bus.RD2D        = 32'h0;
        bus.SignImmD    = 32'h0;
        bus.RsD         = 5'd0;
        bus.RtD         = 5'd0;
        bus.RdD         = 5'd0;
        bus.ALUOutE     = 32'h0;
        bus.WriteDataE  = 32'h0;
        bus.ReadDataM   = 32'h0;

        // Reset held, then released between edges.
        #3;
        check_reset_state("rst_held");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_reset_state("rst_released");

        // Free run: load word through all stages.
        bus.PCNextF  = 32'h0000_0004;
        bus.InstrF   = 32'h8C08_0004;
        bus.PCPlus4F = 32'h0040_0004;
        step();
        check("fr_pcf", bus.PCF, 32'h0000_0004);
        check("fr_instrd", bus.InstrD, 32'h8C08_0004);
        check("fr_pcplus4d", bus.PCPlus4D, 32'h0040_0004);
        bus.InstrF    = 32'h0;
        bus.RegWriteD = 1'b1;
        bus.MemToRegD = 1'b1;
        bus.RegDstD   = 1'b0;
        bus.RtD       = 5'd8;
        bus.RdD       = 5'd3;
        bus.RD1D      = 32'h0000_1000;
        bus.SignImmD  = 32'h0000_0004;
        step();
        check("fr_wrege", {27'd0, bus.WriteRegE}, 32'd8);
        check("fr_regwe", {31'd0, bus.RegWriteE}, 32'd1);
        check("fr_rd1e", bus.RD1E, 32'h0000_1000);
        check("fr_immE", bus.SignImmE, 32'h0000_0004);
        bus.RegWriteD  = 1'b0;
        bus.MemToRegD  = 1'b0;
        bus.RtD        = 5'd0;
        bus.RdD        = 5'd0;
        bus.ALUOutE    = 32'h0000_1234;
        bus.WriteDataE = 32'h0000_5678;
        step();
        check("fr_wregm", {27'd0, bus.WriteRegM}, 32'd8);
        check("fr_regwm", {31'd0, bus.RegWriteM}, 32'd1);
        check("fr_alum", bus.ALUOutM, 32'h0000_1234);
        check("fr_wdm", bus.WriteDataM, 32'h0000_5678);
        check("fr_regwe_next", {31'd0, bus.RegWriteE}, 32'd0);
        bus.ReadDataM = 32'h0000_CAFE;
        step();
        check("fr_wregw", {27'd0, bus.WriteRegW}, 32'd8);
        check("fr_regww", {31'd0, bus.RegWriteW}, 32'd1);
        check("fr_memtoregw", {31'd0, bus.MemToRegW}, 32'd1);
        check("fr_aluw", bus.ALUOutW, 32'h0000_1234);
        check("fr_rdataw", bus.ReadDataW, 32'h0000_CAFE);

        // Load-use stall: set PCF=0x10 and an instruction in D first.
        bus.PCNextF   = 32'h0000_0010;
        bus.InstrF    = 32'hAAAA_0001;
        bus.RegWriteD = 1'b1;
        bus.RtD       = 5'd9;
        step();
        check("lu_pre_pcf", bus.PCF, 32'h0000_0010);
        check("lu_pre_wrege", {27'd0, bus.WriteRegE}, 32'd9);
        bus.StallF  = 1'b1;
        bus.StallD  = 1'b1;
        bus.FlushE  = 1'b1;
        bus.PCNextF = 32'h0000_0014;
        bus.InstrF  = 32'hBBBB_0002;
        bus.RtD     = 5'd10;
        step();
        check("lu_pcf", bus.PCF, 32'h0000_0010);
        check("lu_instrd", bus.InstrD, 32'hAAAA_0001);
        check("lu_regwe", {31'd0, bus.RegWriteE}, 32'd0);
        check("lu_wrege", {27'd0, bus.WriteRegE}, 32'd0);
        check("lu_wregm", {27'd0, bus.WriteRegM}, 32'd9);
        check("lu_stallc", bus.StallCount, 32'd1);
        check("lu_flushc", bus.FlushCount, 32'd1);
        bus.StallF = 1'b0;
        bus.StallD = 1'b0;
        bus.FlushE = 1'b0;
        step();
        check("lu_post_pcf", bus.PCF, 32'h0000_0014);
        check("lu_post_instrd", bus.InstrD, 32'hBBBB_0002);
        check("lu_post_wrege", {27'd0, bus.WriteRegE}, 32'd10);

        // Taken branch: D flushed, E loads normally.
        bus.FlushD   = 1'b1;
        bus.PCNextF  = 32'h0000_0018;
        bus.InstrF   = 32'h1109_0003;
        bus.PCPlus4F = 32'h0000_0018;
        bus.RegDstD  = 1'b1;
        bus.RtD      = 5'd3;
        bus.RdD      = 5'd5;
        step();
        check("br_instrd", bus.InstrD, 32'h0);
        check("br_pcplus4d", bus.PCPlus4D, 32'h0);
        check("br_regwe", {31'd0, bus.RegWriteE}, 32'd1);
        check("br_wrege", {27'd0, bus.WriteRegE}, 32'd5);
        check("br_flushc", bus.FlushCount, 32'd2);

        // Stall and flush on D together: flush wins, PCF held.
        bus.StallF  = 1'b1;
        bus.StallD  = 1'b1;
        bus.PCNextF = 32'h0000_0040;
        bus.InstrF  = 32'h2222_0000;
        step();
        check("sf_instrd", bus.InstrD, 32'h0);
        check("sf_pcf", bus.PCF, 32'h0000_0018);
        check("sf_stallc", bus.StallCount, 32'd2);
        check("sf_flushc", bus.FlushCount, 32'd3);
        bus.StallF = 1'b0;
        bus.StallD = 1'b0;
        bus.FlushD = 1'b0;

        // Counter wrap: preload with StallD low so the forced value is captured as-is.
        force dut.stall_count_q = 32'hFFFF_FFFE;
        step();
        release dut.stall_count_q;
        #1;
        check("wrap_preload", bus.StallCount, 32'hFFFF_FFFE);
        bus.StallD = 1'b1;
        step();
        check("wrap_max", bus.StallCount, 32'hFFFF_FFFF);
        step();
        check("wrap_zero", bus.StallCount, 32'h0);
        bus.StallD = 1'b0;

        // Asynchronous reset mid-run.
        bus.PCNextF = 32'h0000_0080;
        bus.InstrF  = 32'h3333_0000;
        step();
        check("ar_pre_pcf", bus.PCF, 32'h0000_0080);
        #2 reset = 1'b1;
        #1;
        check_reset_state("ar_held");
        bus.PCNextF = 32'h0000_0084;
        #1 reset = 1'b0;
        #1;
        check("ar_released_pcf", bus.PCF, ResetPc);
        step();
        check("ar_first_edge_pcf", bus.PCF, 32'h0000_0084);
        check("ar_first_edge_instrd", bus.InstrD, 32'h3333_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_regs.md
# pipeline_regs

Stage-register bank for the five-stage pipelined MIPS core: holds the PC (F), IF/ID (D), ID/EX (E), EX/MEM (M) and MEM/WB (W) registers. It is the consuming end of the hazard unit's control outputs, StallF, StallD, FlushD and FlushE, and the producing end of the stage fields the hazard unit reads: WriteReg*, RegWrite*, MemToReg* and MemWrite*. It also keeps free-running stall and flush event counters for performance debug.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value loaded into PCF on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- StallF, StallD  in  1  hold F / D register
- FlushD, FlushE  in  1  clear D / E register
- PCNextF  in  32  next PC; PCF  out  32  current fetch PC
- InstrF, PCPlus4F  in  32  fetch outputs; InstrD, PCPlus4D  out  32
- RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD  in  1  decoded controls
- ALUControlD  in  3; RD1D, RD2D, SignImmD  in  32; RsD, RtD, RdD  in  5
- RegWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE  out  1; ALUControlE  out  3
- RD1E, RD2E, SignImmE  out  32; RsE, RtE, RdE  out  5
- WriteRegE  out  5  combinational: RegDstE ? RdE : RtE
- ALUOutE, WriteDataE  in  32  execute results
- RegWriteM, MemToRegM, MemWriteM  out  1; ALUOutM, WriteDataM  out  32; WriteRegM  out  5
- ReadDataM  in  32  data-memory read data
- RegWriteW, MemToRegW, MemWriteW  out  1; ALUOutW, ReadDataW  out  32; WriteRegW  out  5
- StallCount, FlushCount  out  32  event counters

## Operation
- F register (PCF):
  - reset → RESET_PC.
  - Otherwise on each clk edge PCF ← PCNextF unless StallF=1, which holds.
- D register (InstrD, PCPlus4D):
  - reset → 0.
  - FlushD=1 → 0, giving InstrD = 32'h0 (nop). Flush has priority over StallD.
  - Else StallD=1 → hold.
  - Else load InstrF, PCPlus4F.
- E register (all *E fields):
  - reset or FlushE=1 → all fields 0. This gives RegWriteE=MemToRegE=MemWriteE=0, i.e. a bubble.
  - Otherwise load the D-side inputs every cycle. E never stalls.
- M register: loads every cycle and never stalls or flushes.
  - Controls come from E.
  - ALUOutM ← ALUOutE, WriteDataM ← WriteDataE, WriteRegM ← WriteRegE.
- W register: loads every cycle.
  - RegWriteW, MemToRegW and MemWriteW come from M.
  - ALUOutW ← ALUOutM, ReadDataW ← ReadDataM, WriteRegW ← WriteRegM.
  - MemWriteW exists only for store-data forwarding comparison.
- Counters:
  - StallCount += 1 on each edge with StallD=1.
  - FlushCount += 1 on each edge with FlushD|FlushE=1; a cycle with both counts once.
  - Both wrap 32'hFFFF_FFFF → 0. Reset → 0.
- No internal state machine beyond the registers. Stall and flush inputs are sampled at the same edge as the data they gate.

## Timing
- All outputs except WriteRegE are registered.
- Reset value of every registered output is 0, except PCF = RESET_PC. WriteRegE is therefore 0 after reset.
- Latency through the stages, when no stall or flush applies:
  - InstrF → InstrD: 1 edge.
  - D controls → E: 1 edge.
  - E → M: 1 edge.
  - M → W: 1 edge.
  - Total D → W: 3 edges.
- Load-use stall (StallF=StallD=FlushE=1 for one cycle):
  - PCF and InstrD hold one extra cycle.
  - E shows a bubble for that cycle.
  - M and W continue to advance.
- Branch taken (FlushD=1, StallD=0): the instruction in F is discarded and InstrD is 0 next cycle.
- Simultaneous StallD=1 and FlushD=1: D clears (flush wins). StallF still holds PCF.
- reset asserted mid-run:
  - All registers go to reset values immediately, without waiting for clk.
  - On deassertion, the first edge loads PCNextF into PCF.
- Counter wrap: StallCount = 32'hFFFF_FFFF with StallD=1 gives 0 on the next edge.

## Test plan
- Reset with RESET_PC=32'h0040_0000 → PCF=32'h0040_0000 and all other outputs 0, both during reset and before the first edge after release.
- Free run, InstrF=32'h8C08_0004, RegWriteD=1, RegDstD=0, RtD=8 → InstrD matches after 1 edge; WriteRegE=8, RegWriteE=1 after 2; WriteRegM=8 after 3; WriteRegW=8 after 4.
- StallF=StallD=FlushE=1 for one cycle with PCF=32'h10 → PCF stays 32'h10, InstrD holds, RegWriteE=0 next cycle, StallCount=1, FlushCount=1.
- FlushD=1 with InstrF=32'h1109_0003 → InstrD=0 and PCPlus4D=0 next cycle; E loads normally.
- StallD=1 and FlushD=1 together → InstrD=0, FlushCount+1, StallCount+1.
- Preload StallCount to 32'hFFFF_FFFE via 2^32-2 stall cycles, or by forcing it in the bench, then apply 2 stall cycles → StallCount=0; assert reset between clocks → all outputs reset asynchronously.
